// File: rtl/dll_pkg.sv
// Shared definitions for the FMDLL delay-code controller: FSM state encoding
// and default code geometry.
package dll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_TRACK,
    ST_HOLD
  } dll_state_e;

  localparam int DLL_WIDTH_DEF  = 10;
  localparam int DLL_COARSE_DEF = 4;

endpackage

// File: rtl/dll_therm_decode.sv
// Binary-to-thermometer decoder for the coarse delay cells: therm[k] = 1 for k < bin.
module dll_therm_decode #(
  parameter int COARSE_BITS = 4
) (
  input  logic [COARSE_BITS-1:0]      bin,
  output logic [(1<<COARSE_BITS)-1:0] therm
);

  localparam int unsigned N = 1 << COARSE_BITS;

  for (genvar k = 0; k < N; k++) begin : g_therm
    assign therm[k] = (bin > COARSE_BITS'(k));
  end

endmodule

// File: rtl/dll_sar_track_ctrl.sv
// SAR delay-code acquisition with optional filtered +/-1 tracking.
// Tracking is built only when DLL_TRACK_EN is defined; otherwise the search ends in HOLD.
module dll_sar_track_ctrl
  import dll_pkg::*;
#(
  parameter int WIDTH       = DLL_WIDTH_DEF,
  parameter int COARSE_BITS = DLL_COARSE_DEF,
  parameter int FILTER      = 4,
  parameter int LOCK_WIN    = 8
) (
  input  logic                        clk_ext,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        comp_valid,
  input  logic                        comp,
  output logic [WIDTH-1:0]            code,
  output logic [(1<<COARSE_BITS)-1:0] therm,
  output logic                        busy,
  output logic                        done,
  output logic                        locked,
  output logic                        sat
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0]    IDX_TOP  = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] CODE_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 4 || COARSE_BITS < 1 || COARSE_BITS > WIDTH - 1 || FILTER < 1 || LOCK_WIN < 0)
  begin : g_param_check
    $error("dll_sar_track_ctrl: illegal parameter set");
  end

  dll_state_e       state_q, state_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lockf_q, lockf_d;
  logic             restart;

`ifdef DLL_TRACK_EN
  localparam int FW = $clog2(FILTER + 1) + 1;
  localparam logic signed [FW-1:0] FILT_POS = FW'(FILTER);
  localparam logic signed [FW-1:0] FILT_NEG = -FILT_POS;

  logic signed [FW-1:0] filt_q, filt_d, filt_nxt;
  logic [WIDTH-1:0]     ref_q, ref_d;
  logic                 sat_q, sat_d;
  logic signed [WIDTH:0] diff;
  logic [WIDTH:0]       diff_abs;
  logic                 in_win;

  // Extra sign bit keeps code - lock_ref from wrapping near the code bounds.
  always_comb begin
    diff     = $signed({1'b0, code_q}) - $signed({1'b0, ref_q});
    diff_abs = diff[WIDTH] ? (WIDTH+1)'(-diff) : diff;
    in_win   = (32'(diff_abs) <= 32'(LOCK_WIN));
    filt_nxt = comp ? filt_q + FW'(1) : filt_q - FW'(1);
  end
`endif

  assign restart = start && (state_q != ST_SEARCH);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lockf_d = lockf_q;
`ifdef DLL_TRACK_EN
    filt_d  = filt_q;
    ref_d   = ref_q;
    sat_d   = 1'b0;
`endif
    if (restart) begin
      // start outranks a coincident comp_valid outside SEARCH
      state_d = ST_SEARCH;
      code_d  = CODE_MSB;
      idx_d   = IDX_TOP;
      busy_d  = 1'b1;
      lockf_d = 1'b0;
`ifdef DLL_TRACK_EN
      filt_d  = '0;
`endif
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (comp_valid) begin
            if (!comp) code_d[idx_q] = 1'b0;
            if (idx_q != '0) begin
              code_d[idx_q - 1'b1] = 1'b1;
              idx_d = idx_q - 1'b1;
            end else begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              lockf_d = 1'b1;
`ifdef DLL_TRACK_EN
              ref_d   = code_d;
              filt_d  = '0;
              state_d = ST_TRACK;
`else
              state_d = ST_HOLD;
`endif
            end
          end
        end
`ifdef DLL_TRACK_EN
        ST_TRACK: begin
          if (comp_valid) begin
            if (filt_nxt == FILT_POS) begin
              filt_d = '0;
              if (code_q == '1) sat_d = 1'b1;
              else              code_d = code_q + 1'b1;
            end else if (filt_nxt == FILT_NEG) begin
              filt_d = '0;
              if (code_q == '0) sat_d = 1'b1;
              else              code_d = code_q - 1'b1;
            end else begin
              filt_d = filt_nxt;
            end
          end
        end
`endif
        ST_HOLD: ;
        ST_IDLE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      idx_q   <= IDX_TOP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lockf_q <= 1'b0;
`ifdef DLL_TRACK_EN
      filt_q  <= '0;
      ref_q   <= '0;
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lockf_q <= lockf_d;
`ifdef DLL_TRACK_EN
      filt_q  <= filt_d;
      ref_q   <= ref_d;
      sat_q   <= sat_d;
`endif
    end
  end

  dll_therm_decode #(.COARSE_BITS(COARSE_BITS)) u_therm (
    .bin   (code_q[WIDTH-1 -: COARSE_BITS]),
    .therm (therm)
  );

  assign code = code_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef DLL_TRACK_EN
  assign sat    = sat_q;
  assign locked = (state_q == ST_TRACK) ? in_win : lockf_q;
`else
  assign sat    = 1'b0;
  assign locked = lockf_q;
`endif

endmodule
